// File: rtl/fact_job_scheduler.sv
// Memory-mapped job scheduler: queues software operands, dispatches them to the
// lowest free factorial unit, and queues {tag, unit} completion records for software.
module fact_job_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h00002010,
  parameter int          NUM_UNITS = 4,
  parameter int          N_W       = 4,
  parameter int          QDEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              input_addr,
  input  logic                     write_enable,
  input  logic [31:0]              write_data,
  input  logic                     read_enable,
  output logic [31:0]              read_data,
  input  logic [NUM_UNITS-1:0]     done,
  output logic [NUM_UNITS-1:0]     go,
  output logic [NUM_UNITS*N_W-1:0] fact_n,
  output logic                     job_irq
);
  localparam int QPW = $clog2(QDEPTH);
  localparam int QCW = QPW + 1;
  localparam int UW  = $clog2(NUM_UNITS);
  localparam logic [QCW-1:0] QFULL = QCW'(QDEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;

  logic [N_W+3:0]         req_mem [QDEPTH];  // {tag, n}
  logic [QPW-1:0]         req_wr, req_rd;
  logic [QCW-1:0]         req_count;
  logic [UW+3:0]          cmp_mem [QDEPTH];  // {tag, unit}
  logic [QPW-1:0]         cmp_wr, cmp_rd;
  logic [QCW-1:0]         cmp_count;
  logic [NUM_UNITS-1:0]   busy, pend;
  logic [3:0]             unit_tag [NUM_UNITS];
  logic [3:0]             tag;
  logic                   ovf;

  logic sel_submit, sel_complete, sel_status;
  logic submit_wr, req_push, cmp_pop;
  logic disp_ok, drain_ok;
  logic [UW-1:0]        disp_idx, drain_idx;
  logic [NUM_UNITS-1:0] free, done_hit, disp_mask, drain_mask;

  assign sel_submit   = (input_addr == BASE_ADDR);
  assign sel_complete = (input_addr == BASE_ADDR + 32'd4);
  assign sel_status   = (input_addr == BASE_ADDR + 32'd8);
  assign submit_wr    = write_enable && sel_submit;
  assign req_push     = submit_wr && (req_count != QFULL);
  assign cmp_pop      = read_enable && sel_complete && (cmp_count != '0);
  assign free         = ~busy & ~pend;
  assign done_hit     = done & busy;
  assign job_irq      = (cmp_count != '0);

  // Eligibility uses registered busy/pend only, so a unit finishing this cycle waits.
  always_comb begin
    disp_idx  = '0;
    drain_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (free[i]) disp_idx = UW'(i);
      if (pend[i]) drain_idx = UW'(i);
    end
    disp_ok    = (state == IDLE) && (req_count != '0) && (free != '0);
    drain_ok   = (pend != '0) && (cmp_count != QFULL);
    disp_mask  = disp_ok  ? (NUM_UNITS'(1) << disp_idx)  : '0;
    drain_mask = drain_ok ? (NUM_UNITS'(1) << drain_idx) : '0;
  end

  always_comb begin
    read_data = '0;
    if (sel_complete && (cmp_count != '0))
      read_data = {1'b1, 25'b0, cmp_mem[cmp_rd]};
    else if (sel_status)
      read_data = {ovf, 16'b0, cmp_count, 1'b0, req_count, pend, busy};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      go        <= '0;
      fact_n    <= '0;
      busy      <= '0;
      pend      <= '0;
      tag       <= '0;
      ovf       <= 1'b0;
      req_wr    <= '0;
      req_rd    <= '0;
      req_count <= '0;
      cmp_wr    <= '0;
      cmp_rd    <= '0;
      cmp_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        req_mem[i] <= '0;
        cmp_mem[i] <= '0;
      end
      for (int i = 0; i < NUM_UNITS; i++) unit_tag[i] <= '0;
    end else begin
      if (submit_wr) begin
        if (req_push) begin
          req_mem[req_wr] <= {tag, write_data[N_W-1:0]};
          req_wr          <= req_wr + 1'b1;
          tag             <= tag + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
      if (write_enable && sel_status) ovf <= 1'b0;

      case (state)
        IDLE: begin
          go <= '0;
          if (disp_ok) begin
            go                              <= disp_mask;
            fact_n[disp_idx*N_W +: N_W]     <= req_mem[req_rd][N_W-1:0];
            unit_tag[disp_idx]              <= req_mem[req_rd][N_W+3:N_W];
            req_rd                          <= req_rd + 1'b1;
            state                           <= ISSUE;
          end
        end
        ISSUE: begin
          go    <= '0;
          state <= IDLE;
        end
        default: begin
          go    <= '0;
          state <= IDLE;
        end
      endcase
      req_count <= req_count + QCW'(req_push) - QCW'(disp_ok);

      // A pending unit is never redispatched, so its record waits for FIFO space.
      busy <= (busy & ~done_hit) | disp_mask;
      pend <= (pend | done_hit) & ~drain_mask;

      if (drain_ok) begin
        cmp_mem[cmp_wr] <= {unit_tag[drain_idx], drain_idx};
        cmp_wr          <= cmp_wr + 1'b1;
      end
      if (cmp_pop) cmp_rd <= cmp_rd + 1'b1;
      cmp_count <= cmp_count + QCW'(drain_ok) - QCW'(cmp_pop);
    end
  end
endmodule

// File: tb/tb_fact_job_scheduler.sv
// Directed bench for fact_job_scheduler: dispatch order, overflow, completion drain and reset.
module tb_fact_job_scheduler;
  localparam logic [31:0] SUBMIT   = 32'h00002010;
  localparam logic [31:0] COMPLETE = 32'h00002014;
  localparam logic [31:0] STATUS   = 32'h00002018;

  logic        clk, rst;
  logic [31:0] input_addr, write_data, read_data;
  logic        write_enable, read_enable, job_irq;
  logic [3:0]  done, go;
  logic [15:0] fact_n;
  int checks = 0;
  int errors = 0;

  fact_job_scheduler dut (
    .clk(clk), .rst(rst), .input_addr(input_addr), .write_enable(write_enable),
    .write_data(write_data), .read_enable(read_enable), .read_data(read_data),
    .done(done), .go(go), .fact_n(fact_n), .job_irq(job_irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    input_addr = a;
    #1;
    chk(name, read_data, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    input_addr   = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic submit_burst(input int cnt, input int n0);
    for (int k = 0; k < cnt; k++) begin
      input_addr   = SUBMIT;
      write_data   = 32'(n0 + k);
      write_enable = 1'b1;
      tick();
    end
    write_enable = 1'b0;
  endtask

  task automatic pop();
    input_addr  = COMPLETE;
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    done = m;
    tick();
    done = 4'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    done = 4'b0;
    write_enable = 1'b0;
    read_enable = 1'b0;
    write_data = '0;
    input_addr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, single job round trip
    do_reset();
    chk("rst_go", 32'(go), 32'h0);
    chk("rst_irq", 32'(job_irq), 32'h0);
    chk_rd("rst_status", STATUS, 32'h0);
    chk_rd("rst_complete", COMPLETE, 32'h0);
    wr(SUBMIT, 32'd5);
    chk("s1_go_t", 32'(go), 32'h0);
    tick();
    chk("s1_go_t1", 32'(go), 32'h1);
    chk("s1_fact_n", 32'(fact_n), 32'h0005);
    tick();
    chk("s1_go_t2", 32'(go), 32'h0);
    chk_rd("s1_status_busy", STATUS, 32'h00000001);
    pulse(4'b0001);
    chk_rd("s1_status_pend", STATUS, 32'h00000010);
    chk("s1_irq_pre", 32'(job_irq), 32'h0);
    tick();
    chk("s1_irq", 32'(job_irq), 32'h1);
    chk_rd("s1_complete", COMPLETE, 32'h80000000);
    pop();
    chk("s1_irq_pop", 32'(job_irq), 32'h0);
    chk_rd("s1_complete_empty", COMPLETE, 32'h0);

    // Five back-to-back jobs, 2-cycle dispatch spacing
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      if (k <= 5) begin
        input_addr   = SUBMIT;
        write_data   = 32'(k);
        write_enable = 1'b1;
      end else begin
        write_enable = 1'b0;
      end
      tick();
      chk($sformatf("s2_go_%0d", k), 32'(go), (k % 2 == 0) ? (32'h1 << (k / 2 - 1)) : 32'h0);
    end
    write_enable = 1'b0;
    chk("s2_fact_n", 32'(fact_n), 32'h4321);
    chk_rd("s2_status", STATUS, 32'h0000010F);
    pulse(4'b0100);
    tick();
    chk("s2_go_pend_block", 32'(go), 32'h0);
    tick();
    chk("s2_go_redispatch", 32'(go), 32'h4);
    chk("s2_fact_n2", 32'(fact_n), 32'h4521);
    chk_rd("s2_cmp_tag2", COMPLETE, 32'h8000000A);
    pop();
    pulse(4'b0100);
    tick();
    chk_rd("s2_cmp_tag4", COMPLETE, 32'h80000012);
    pop();

    // Request FIFO overflow and ovf clear
    do_reset();
    submit_burst(4, 1);
    idle(5);
    chk_rd("s3_all_busy", STATUS, 32'h0000000F);
    submit_burst(5, 6);
    chk_rd("s3_ovf", STATUS, 32'h8000040F);
    wr(STATUS, 32'h00001234);
    chk_rd("s3_ovf_clr", STATUS, 32'h0000040F);

    // Simultaneous done on all units
    pulse(4'b1111);
    idle(4);
    chk_rd("s4_status", STATUS, 32'h00004203);
    chk("s4_irq", 32'(job_irq), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk_rd($sformatf("s4_cmp_%0d", i), COMPLETE, 32'h80000000 | 32'((i << 2) | i));
      pop();
    end
    chk("s4_go_u3", 32'(go), 32'h8);
    chk_rd("s4_cmp_empty", COMPLETE, 32'h0);
    chk("s4_fact_n", 32'(fact_n), 32'h9876);
    tick();
    wr(SUBMIT, 32'd3);
    pulse(4'b1111);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      chk_rd($sformatf("s4_cmp2_%0d", i), COMPLETE, 32'h80000000 | 32'(((4 + i) << 2) | i));
      pop();
    end
    pulse(4'b0001);
    tick();
    chk_rd("s4_tag8", COMPLETE, 32'h80000020);
    pop();
    chk("s4_irq_end", 32'(job_irq), 32'h0);

    // Completion FIFO full holds a pending unit back
    do_reset();
    submit_burst(4, 1);
    idle(5);
    pulse(4'b1111);
    idle(4);
    chk_rd("s5_cmp_full", STATUS, 32'h00004000);
    submit_burst(6, 10);
    idle(3);
    chk_rd("s5_status_q", STATUS, 32'h0000420F);
    pulse(4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s5_no_go_%0d", i), 32'(go), 32'h0);
    end
    chk_rd("s5_status_pend", STATUS, 32'h0000422D);
    chk_rd("s5_head", COMPLETE, 32'h80000000);
    pop();
    chk_rd("s5_after_pop", STATUS, 32'h0000322D);
    tick();
    chk_rd("s5_drained", STATUS, 32'h0000420D);
    chk("s5_go_wait", 32'(go), 32'h0);
    tick();
    chk("s5_go_u1", 32'(go), 32'h2);
    chk("s5_fact_n", 32'(fact_n), 32'hDCEA);

    // Asynchronous reset mid-activity, late done ignored
    do_reset();
    submit_burst(4, 1);
    chk("s6_go_before", 32'(go), 32'h2);
    rst = 1'b1;
    #1;
    chk("s6_go_rst", 32'(go), 32'h0);
    chk("s6_fact_n_rst", 32'(fact_n), 32'h0);
    chk("s6_irq_rst", 32'(job_irq), 32'h0);
    chk_rd("s6_status_rst", STATUS, 32'h0);
    done = 4'b0001;
    tick();
    done = 4'b0;
    rst = 1'b0;
    pulse(4'b0001);
    idle(2);
    chk("s6_irq_late", 32'(job_irq), 32'h0);
    chk("s6_go_late", 32'(go), 32'h0);
    chk_rd("s6_status_late", STATUS, 32'h0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
